// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state encoding and default timing constants for countdown_ctrl
package countdown_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int TICK_DIV_DEF        = 4194304;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronise, debounce and rising-edge detect one active-low push-button
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W            = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press
);
    logic [1:0]      sync_q;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            level_q, level_d, press_q, press_d, lvl, done;
    always_comb begin
        lvl     = ~sync_q[1];
        done    = cnt_q == DB_W'(DEBOUNCE_CYCLES - 1);
        cnt_d   = (lvl == level_q || done) ? '0 : cnt_q + 1'b1;
        level_d = (lvl != level_q && done) ? lvl : level_q;
        press_d = level_d & ~level_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_n};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end
    assign level = level_q;
    assign press = press_q;
endmodule

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: debounced START/CLEAR front-end and RUN/PAUSE/DONE control for the 99-to-00 counter
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int DB_W            = 20,
    parameter int TICK_DIV        = TICK_DIV_DEF,
    parameter int TICK_W          = 22
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_start_n,
    input  logic       key_clear_n,
    input  logic       zero_reached,
    output logic       count_en,
    output logic       clear,
    output logic [1:0] state,
    output logic       led_run,
    output logic       led_done
);
    state_t            state_q, state_d;
    logic [TICK_W-1:0] pre_q, pre_d;
    logic              count_en_q, count_en_d, clear_q, clear_d, led_run_q, led_done_q;
    logic              start_press, clear_press, tick;
    logic [1:0]        level_unused;
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_start (
        .clk   (clk),
        .reset (reset),
        .key_n (key_start_n),
        .level (level_unused[0]),
        .press (start_press)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_clear (
        .clk   (clk),
        .reset (reset),
        .key_n (key_clear_n),
        .level (level_unused[1]),
        .press (clear_press)
    );
    always_comb begin
        tick       = pre_q == TICK_W'(TICK_DIV - 1);
        state_d    = state_q;
        pre_d      = '0;
        count_en_d = 1'b0;
        clear_d    = 1'b0;
        unique case (state_q)
            ST_IDLE:  state_d = start_press ? ST_RUN : ST_IDLE;
            ST_RUN: begin
                pre_d      = tick ? '0 : start_press ? pre_q : pre_q + 1'b1;
                count_en_d = tick & ~zero_reached;
                state_d    = (tick & zero_reached) ? ST_DONE : start_press ? ST_PAUSE : ST_RUN;
            end
            ST_PAUSE: begin
                pre_d   = pre_q;
                state_d = start_press ? ST_RUN : ST_PAUSE;
            end
            ST_DONE: begin
                clear_d = start_press;
                state_d = start_press ? ST_RUN : ST_DONE;
            end
        endcase
        if (clear_press) begin
            state_d    = ST_IDLE;
            pre_d      = '0;
            count_en_d = 1'b0;
            clear_d    = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pre_q      <= '0;
            count_en_q <= 1'b0;
            clear_q    <= 1'b0;
            led_run_q  <= 1'b0;
            led_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            count_en_q <= count_en_d;
            clear_q    <= clear_d;
            led_run_q  <= state_d == ST_RUN;
            led_done_q <= state_d == ST_DONE;
        end
    end
    assign count_en = count_en_q;
    assign clear    = clear_q;
    assign state    = state_q;
    assign led_run  = led_run_q;
    assign led_done = led_done_q;
endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: event scoreboard against a behavioural model, directed plan then random buttons
module tb_countdown_ctrl;
    import countdown_pkg::*;
    localparam int DB = 4;
    localparam int TD = 8;
    typedef struct {
        int       kind;
        int       cyc;
        bit [1:0] st;
    } ev_t;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_start_n = 1'b1;
    logic       key_clear_n = 1'b1;
    logic       zero_reached = 1'b0;
    logic       count_en, clear, led_run, led_done;
    logic [1:0] state;
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         ce_cnt = 0;
    int         clr_cnt = 0;
    ev_t        exp_q[$];
    bit         m_rst = 1'b1;
    bit [1:0]   m_st = 2'd0;
    int         m_run = 0;
    bit [1:0]   raw_h[2];
    bit [DB-1:0] lv_h[2];
    int         lv_n[2];
    bit         stable[2];
    bit         pend[2];
    bit [1:0]   prev_st = 2'd0;
    countdown_ctrl #(.DEBOUNCE_CYCLES(DB), .DB_W(3), .TICK_DIV(TD), .TICK_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_start_n  (key_start_n),
        .key_clear_n  (key_clear_n),
        .zero_reached (zero_reached),
        .count_en     (count_en),
        .clear        (clear),
        .state        (state),
        .led_run      (led_run),
        .led_done     (led_done)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask
    task automatic push(input int kind, input bit [1:0] st);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc;
        e.st   = st;
        exp_q.push_back(e);
    endtask
    task automatic check_ev(input int kind);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d state %0d, expected none", kind, cyc, state);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.st != state) begin
                n_fail++;
                $display("FAIL event: got kind %0d cycle %0d state %0d, expected kind %0d cycle %0d state %0d",
                         kind, cyc, state, e.kind, e.cyc, e.st);
            end
        end
    endtask
    // Reference model: buttons accepted after DB consecutive disagreeing synced samples,
    // prescaler phase kept as a count of cycles spent running.
    always @(posedge clk) begin
        bit       sp, cp, ce, cl, lvl, raw;
        bit [1:0] old;
        cyc++;
        m_rst = reset;
        if (reset) begin
            m_st  = ST_IDLE;
            m_run = 0;
            for (int b = 0; b < 2; b++) begin
                raw_h[b]  = 2'b11;
                lv_h[b]   = '0;
                lv_n[b]   = 0;
                stable[b] = 1'b0;
                pend[b]   = 1'b0;
            end
        end else begin
            sp  = pend[0];
            cp  = pend[1];
            old = m_st;
            ce  = 1'b0;
            cl  = 1'b0;
            if (cp) begin
                m_st  = ST_IDLE;
                m_run = 0;
                cl    = 1'b1;
            end else if (m_st == ST_IDLE) begin
                if (sp) begin
                    m_st  = ST_RUN;
                    m_run = 0;
                end
            end else if (m_st == ST_RUN) begin
                if (m_run % TD == TD - 1) begin
                    m_run++;
                    if (zero_reached) m_st = ST_DONE;
                    else begin
                        ce = 1'b1;
                        if (sp) m_st = ST_PAUSE;
                    end
                end else if (sp) m_st = ST_PAUSE;
                else m_run++;
            end else if (m_st == ST_PAUSE) begin
                if (sp) m_st = ST_RUN;
            end else if (sp) begin
                m_st  = ST_RUN;
                m_run = 0;
                cl    = 1'b1;
            end
            if (ce) push(0, m_st);
            if (cl) push(1, m_st);
            if (m_st != old) push(2, m_st);
            for (int b = 0; b < 2; b++) begin
                raw      = (b == 0) ? key_start_n : key_clear_n;
                lvl      = ~raw_h[b][1];
                raw_h[b] = {raw_h[b][0], raw};
                lv_h[b]  = {lv_h[b][DB-2:0], lvl};
                lv_n[b]++;
                pend[b]  = 1'b0;
                if (lv_n[b] >= DB && lv_h[b] == {DB{~stable[b]}}) begin
                    stable[b] = ~stable[b];
                    pend[b]   = stable[b];
                    lv_n[b]   = 0;
                end
            end
        end
    end
    always @(negedge clk) begin
        if (m_rst) prev_st = state;
        else begin
            if (count_en) begin
                ce_cnt++;
                check_ev(0);
            end
            if (clear) begin
                clr_cnt++;
                check_ev(1);
            end
            if (state != prev_st) check_ev(2);
            prev_st = state;
            chk("state", state, m_st);
            chk("led_run", led_run, m_st == ST_RUN);
            chk("led_done", led_done, m_st == ST_DONE);
            chk("en_and_clear", count_en & clear, 0);
        end
    end
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic nsync();
        @(negedge clk);
        #1;
    endtask
    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic hold(input bit s, input bit c, input int n);
        if (s) key_start_n = 1'b0;
        if (c) key_clear_n = 1'b0;
        step(n);
        key_start_n = 1'b1;
        key_clear_n = 1'b1;
    endtask
    task automatic chatter(input bit s, input bit c, input int n);
        for (int i = 0; i < n; i++) begin
            if (s) key_start_n = ($urandom_range(0, 7) == 0);
            if (c) key_clear_n = ($urandom_range(0, 7) == 0);
            step(1);
        end
        key_start_n = 1'b1;
        key_clear_n = 1'b1;
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        int e, r, s, ce0, clr0;
        step(3);
        reset = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_count_en", count_en, 0);
        chk("rst_clear", clear, 0);
        chk("rst_led_run", led_run, 0);
        chk("rst_led_done", led_done, 0);
        ce0 = ce_cnt;
        step(20);
        nsync();
        chk("idle_no_count", ce_cnt - ce0, 0);
        hold(1, 0, 3);
        step(12);
        chk("short_press_ignored", state, ST_IDLE);
        key_start_n = 1'b0;
        step(6);
        chk("press_latency_early", state, ST_IDLE);
        step(1);
        chk("press_latency_run", state, ST_RUN);
        e   = cyc;
        ce0 = ce_cnt;
        step(3);
        key_start_n = 1'b1;
        wait_to(e + 40);
        nsync();
        chk("run_40_cycles_pulses", ce_cnt - ce0, 5);
        wait_to(e + 47);
        hold(1, 0, 6);
        step(1);
        chk("pause_entry", state, ST_PAUSE);
        ce0 = ce_cnt;
        step(30);
        nsync();
        chk("pause_no_count", ce_cnt - ce0, 0);
        hold(1, 0, 6);
        step(1);
        chk("resume_run", state, ST_RUN);
        r   = cyc;
        ce0 = ce_cnt;
        step(2);
        nsync();
        chk("resume_phase_early", ce_cnt - ce0, 0);
        step(1);
        nsync();
        chk("resume_phase_tick", ce_cnt - ce0, 1);
        ce0 = ce_cnt;
        zero_reached = 1'b1;
        wait_to(r + 10);
        chk("before_zero_tick", state, ST_RUN);
        step(1);
        chk("done_state", state, ST_DONE);
        chk("done_led", led_done, 1);
        nsync();
        chk("zero_tick_no_count", ce_cnt - ce0, 0);
        zero_reached = 1'b0;
        clr0 = clr_cnt;
        hold(1, 0, 6);
        step(1);
        chk("restart_run", state, ST_RUN);
        s = cyc;
        nsync();
        chk("restart_clear", clr_cnt - clr0, 1);
        ce0 = ce_cnt;
        wait_to(s + 7);
        nsync();
        chk("restart_phase_early", ce_cnt - ce0, 0);
        step(1);
        nsync();
        chk("restart_phase_tick", ce_cnt - ce0, 1);
        clr0 = clr_cnt;
        hold(1, 1, 6);
        step(1);
        chk("clear_wins_state", state, ST_IDLE);
        nsync();
        chk("clear_wins_pulse", clr_cnt - clr0, 1);
        key_start_n = 1'b0;
        step(4);
        reset       = 1'b1;
        key_start_n = 1'b1;
        step(2);
        reset = 1'b0;
        step(20);
        chk("reset_mid_debounce", state, ST_IDLE);
        for (int i = 0; i < 160; i++) begin
            r = $urandom_range(0, 99);
            if (r < 40) chatter(1, 0, $urandom_range(1, 9));
            else if (r < 50) chatter(0, 1, $urandom_range(1, 9));
            else if (r < 55) hold(1, 1, $urandom_range(3, 7));
            else if (r < 72) zero_reached = ~zero_reached;
            else if (r < 76) begin
                reset = 1'b1;
                step($urandom_range(1, 3));
                reset = 1'b0;
            end else step($urandom_range(1, 40));
            step($urandom_range(1, 10));
        end
        step(5);
        nsync();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
